// File: rtl/ysyx_22050243_pkg.sv
// Shared decode definitions for the ID stage: opcodes, field encodings and the control bundle.
package ysyx_22050243_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  FUNCT7_MEXT = 7'b0000001;
    localparam logic [31:0] EBREAK      = 32'h00100073;

    typedef enum logic [2:0] {
        M2R_ALU   = 3'b000,
        M2R_MEM   = 3'b001,
        M2R_IMM   = 3'b010,
        M2R_PC4   = 3'b011,
        M2R_PCIMM = 3'b100,
        M2R_CSR   = 3'b101
    } mem2reg_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JAL  = 2'b01,
        PC_JALR = 2'b10
    } pc_src_e;

    typedef enum logic [3:0] {
        ALU_NONE    = 4'b0000,
        ALU_BRANCH  = 4'b0001,
        ALU_OP      = 4'b0010,
        ALU_OP_IMM  = 4'b0011,
        ALU_OP32    = 4'b0110,
        ALU_OP_IMM32 = 4'b0111,
        ALU_MUL     = 4'b1000,
        ALU_MUL32   = 4'b1001
    } alu_op_e;

    typedef struct packed {
        logic     csr_r;
        logic     alu_src;
        mem2reg_e mem2reg;
        logic     reg_w;
        logic     mem_r;
        logic     mem_w;
        logic     branch;
        pc_src_e  pc_src;
        alu_op_e  alu_op;
        logic     illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ysyx_22050243_ctrl_dec.sv
// Combinational instruction decoder: 32-bit instruction word to control bundle,
// with illegal flagging for the current XLEN / M-extension configuration.
module ysyx_22050243_ctrl_dec
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit HAS_M = 1'b1
) (
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    logic       m_ext;
    logic       bad;

    assign opcode = inst_i[6:0];
    assign m_ext  = (inst_i[31:25] == FUNCT7_MEXT);

    always_comb begin
        // NOTE: every output gets a default before the case so no path through it infers a latch.
        ctrl_o = CTRL_NOP;
        bad    = 1'b0;
        case (opcode)
            OPC_LUI:   begin ctrl_o.mem2reg = M2R_IMM;   ctrl_o.reg_w = 1'b1; end
            OPC_AUIPC: begin ctrl_o.mem2reg = M2R_PCIMM; ctrl_o.reg_w = 1'b1; end
            OPC_JAL: begin
                ctrl_o.mem2reg = M2R_PC4;
                ctrl_o.reg_w   = 1'b1;
                ctrl_o.pc_src  = PC_JAL;
            end
            OPC_JALR: begin
                ctrl_o.mem2reg = M2R_PC4;
                ctrl_o.reg_w   = 1'b1;
                ctrl_o.pc_src  = PC_JALR;
            end
            OPC_BRANCH: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BRANCH; end
            OPC_LOAD: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.mem2reg = M2R_MEM;
                ctrl_o.reg_w   = 1'b1;
                ctrl_o.mem_r   = 1'b1;
            end
            OPC_STORE: begin ctrl_o.alu_src = 1'b1; ctrl_o.mem_w = 1'b1; end
            OPC_OP_IMM: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_w   = 1'b1;
                ctrl_o.alu_op  = ALU_OP_IMM;
            end
            OPC_OP: begin
                bad           = m_ext && !HAS_M;
                ctrl_o.reg_w  = 1'b1;
                ctrl_o.alu_op = m_ext ? ALU_MUL : ALU_OP;
            end
            OPC_OP_IMM32: begin
                bad            = (XLEN == 32);
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_w   = 1'b1;
                ctrl_o.alu_op  = ALU_OP_IMM32;
            end
            OPC_OP_32: begin
                bad           = (XLEN == 32) || (m_ext && !HAS_M);
                ctrl_o.reg_w  = 1'b1;
                ctrl_o.alu_op = m_ext ? ALU_MUL32 : ALU_OP32;
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                // funct3 == 0 covers ecall/ebreak/xret, which need no writeback.
                if (inst_i[14:12] != 3'b000) begin
                    ctrl_o.csr_r   = 1'b1;
                    ctrl_o.mem2reg = M2R_CSR;
                    ctrl_o.reg_w   = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad || inst_i == 32'h0) begin
            ctrl_o         = CTRL_NOP;
            ctrl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050243_id_ctrl_stage.sv
// Registered ID/control stage: decodes at the input, holds the bundle in an output
// register backed by a 1-entry skid buffer, and latches a sticky halt on ebreak.
module ysyx_22050243_id_ctrl_stage
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit HAS_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_alu_src,
    output logic [2:0]      out_mem2reg,
    output logic            out_reg_w,
    output logic            out_mem_r,
    output logic            out_mem_w,
    output logic            out_branch,
    output logic [1:0]      out_pc_src,
    output logic [3:0]      out_alu_op,
    output logic            out_csr_r,
    output logic            out_illegal,
    output logic            halted
);

    ctrl_t dec_ctrl;

    logic            rst_done_q;
    logic            out_valid_q,  out_valid_d;
    logic [31:0]     out_inst_q,   out_inst_d;
    logic [XLEN-1:0] out_pc_q,     out_pc_d;
    ctrl_t           out_ctrl_q,   out_ctrl_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_inst_q,  skid_inst_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    ctrl_t           skid_ctrl_q,  skid_ctrl_d;
    logic            halted_q,     halted_d;

    logic accept, out_fire, out_free;

    ysyx_22050243_ctrl_dec #(.XLEN(XLEN), .HAS_M(HAS_M)) u_dec (
        .inst_i (in_inst),
        .ctrl_o (dec_ctrl)
    );

    // in_ready depends only on flops, so nothing from out_ready reaches IF combinationally.
    assign in_ready = rst_done_q && !skid_valid_q && !halted_q;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_ctrl_d   = out_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_ctrl_d  = skid_ctrl_q;
        halted_d     = halted_q || (out_fire && out_inst_q == EBREAK);

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_pc_d     = skid_pc_q;
                out_ctrl_d   = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_inst_d = in_inst;
                    out_pc_d   = in_pc;
                    out_ctrl_d = dec_ctrl;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = in_inst;
            skid_pc_d    = in_pc;
            skid_ctrl_d  = dec_ctrl;
        end
    end

    // NOTE: payload registers are reset too so every output reads 0 while rst_n is low;
    // state uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_ctrl_q   <= CTRL_NOP;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_ctrl_q  <= CTRL_NOP;
            halted_q     <= 1'b0;
        end else begin
            rst_done_q   <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_ctrl_q   <= out_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_ctrl_q  <= skid_ctrl_d;
            halted_q     <= halted_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign out_alu_src = out_ctrl_q.alu_src;
    assign out_mem2reg = out_ctrl_q.mem2reg;
    assign out_reg_w   = out_ctrl_q.reg_w;
    assign out_mem_r   = out_ctrl_q.mem_r;
    assign out_mem_w   = out_ctrl_q.mem_w;
    assign out_branch  = out_ctrl_q.branch;
    assign out_pc_src  = out_ctrl_q.pc_src;
    assign out_alu_op  = out_ctrl_q.alu_op;
    assign out_csr_r   = out_ctrl_q.csr_r;
    assign out_illegal = out_ctrl_q.illegal;
    assign halted      = halted_q;

endmodule

// File: tb/tb_ysyx_22050243_id_ctrl_stage.sv
// Scoreboard bench: three stage instances (default, XLEN=32, HAS_M=0) share one stimulus
// stream; a queue-based reference model predicts each emitted bundle and the halt flag.
module tb_ysyx_22050243_id_ctrl_stage;

    localparam logic [31:0] EBREAK_W = 32'h00100073;
    localparam logic [31:0] ADDI     = 32'h00500093;
    localparam logic [31:0] LUI      = 32'h123450b7;
    localparam logic [31:0] LOAD     = 32'h0000b103;
    localparam logic [31:0] STORE    = 32'h0020b423;
    localparam logic [31:0] ADDW     = 32'h002081bb;
    localparam logic [31:0] MUL      = 32'h022080b3;

    typedef struct packed {
        logic       csr_r;
        logic       alu_src;
        logic [2:0] m2r;
        logic       reg_w;
        logic       mem_r;
        logic       mem_w;
        logic       branch;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic       illegal;
    } bun_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        bun_t        b64;
        bun_t        b32;
        bun_t        bnm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        d_in_ready, d_out_valid, d_alu_src, d_reg_w, d_mem_r, d_mem_w, d_branch, d_csr_r, d_illegal, d_halted;
    logic [2:0]  d_mem2reg;
    logic [1:0]  d_pc_src;
    logic [3:0]  d_alu_op;
    logic [31:0] d_inst;
    logic [63:0] d_pc;
    logic        x_in_ready, x_out_valid, x_alu_src, x_reg_w, x_mem_r, x_mem_w, x_branch, x_csr_r, x_illegal, x_halted;
    logic [2:0]  x_mem2reg;
    logic [1:0]  x_pc_src;
    logic [3:0]  x_alu_op;
    logic [31:0] x_inst;
    logic [31:0] x_pc;
    logic        n_in_ready, n_out_valid, n_alu_src, n_reg_w, n_mem_r, n_mem_w, n_branch, n_csr_r, n_illegal, n_halted;
    logic [2:0]  n_mem2reg;
    logic [1:0]  n_pc_src;
    logic [3:0]  n_alu_op;
    logic [31:0] n_inst;
    logic [63:0] n_pc;

    bun_t act_d, act_x, act_n;
    assign act_d = {d_csr_r, d_alu_src, d_mem2reg, d_reg_w, d_mem_r, d_mem_w, d_branch, d_pc_src, d_alu_op, d_illegal};
    assign act_x = {x_csr_r, x_alu_src, x_mem2reg, x_reg_w, x_mem_r, x_mem_w, x_branch, x_pc_src, x_alu_op, x_illegal};
    assign act_n = {n_csr_r, n_alu_src, n_mem2reg, n_reg_w, n_mem_r, n_mem_w, n_branch, n_pc_src, n_alu_op, n_illegal};

    ysyx_22050243_id_ctrl_stage u_d (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_inst(d_inst), .out_pc(d_pc), .out_alu_src(d_alu_src), .out_mem2reg(d_mem2reg),
        .out_reg_w(d_reg_w), .out_mem_r(d_mem_r), .out_mem_w(d_mem_w), .out_branch(d_branch),
        .out_pc_src(d_pc_src), .out_alu_op(d_alu_op), .out_csr_r(d_csr_r), .out_illegal(d_illegal),
        .halted(d_halted)
    );

    ysyx_22050243_id_ctrl_stage #(.XLEN(32)) u_x (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(x_out_valid), .out_ready(out_ready),
        .out_inst(x_inst), .out_pc(x_pc), .out_alu_src(x_alu_src), .out_mem2reg(x_mem2reg),
        .out_reg_w(x_reg_w), .out_mem_r(x_mem_r), .out_mem_w(x_mem_w), .out_branch(x_branch),
        .out_pc_src(x_pc_src), .out_alu_op(x_alu_op), .out_csr_r(x_csr_r), .out_illegal(x_illegal),
        .halted(x_halted)
    );

    ysyx_22050243_id_ctrl_stage #(.HAS_M(1'b0)) u_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_inst(n_inst), .out_pc(n_pc), .out_alu_src(n_alu_src), .out_mem2reg(n_mem2reg),
        .out_reg_w(n_reg_w), .out_mem_r(n_mem_r), .out_mem_w(n_mem_w), .out_branch(n_branch),
        .out_pc_src(n_pc_src), .out_alu_op(n_alu_op), .out_csr_r(n_csr_r), .out_illegal(n_illegal),
        .halted(n_halted)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   halted_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic bun_t ref_dec(input logic [31:0] w, input int xlen, input bit has_m);
        bun_t b = '0;
        bit   bad = 1'b0;
        bit   mx = (w[31:25] == 7'b0000001);
        case (w[6:0])
            7'h37: begin b.m2r = 3'd2; b.reg_w = 1; end
            7'h17: begin b.m2r = 3'd4; b.reg_w = 1; end
            7'h6f: begin b.m2r = 3'd3; b.reg_w = 1; b.pc_src = 2'd1; end
            7'h67: begin b.m2r = 3'd3; b.reg_w = 1; b.pc_src = 2'd2; end
            7'h63: begin b.branch = 1; b.alu_op = 4'd1; end
            7'h03: begin b.alu_src = 1; b.m2r = 3'd1; b.reg_w = 1; b.mem_r = 1; end
            7'h23: begin b.alu_src = 1; b.mem_w = 1; end
            7'h13: begin b.alu_src = 1; b.reg_w = 1; b.alu_op = 4'd3; end
            7'h33: begin
                if (mx && !has_m) bad = 1;
                else begin b.reg_w = 1; b.alu_op = mx ? 4'd8 : 4'd2; end
            end
            7'h1b: begin
                if (xlen == 32) bad = 1;
                else begin b.alu_src = 1; b.reg_w = 1; b.alu_op = 4'd7; end
            end
            7'h3b: begin
                if (xlen == 32 || (mx && !has_m)) bad = 1;
                else begin b.reg_w = 1; b.alu_op = mx ? 4'd9 : 4'd6; end
            end
            7'h0f: ;
            7'h73: if (w[14:12] != 3'b000) begin b.csr_r = 1; b.m2r = 3'd5; b.reg_w = 1; end
            default: bad = 1;
        endcase
        if (bad || w == 32'h0) begin
            b = '0;
            b.illegal = 1;
        end
        return b;
    endfunction

    function automatic exp_t mk(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        e.inst = w;
        e.pc   = pc;
        e.b64  = ref_dec(w, 64, 1'b1);
        e.b32  = ref_dec(w, 32, 1'b1);
        e.bnm  = ref_dec(w, 64, 1'b0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [13];
        logic [31:0] w = $urandom();
        int          k = $urandom_range(0, 16);
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h0f, 7'h73};
        if (k < 13) w[6:0] = ops[k];
        else if (k == 13) w = 32'h0;
        else if (k == 14) begin
            w[6:0]   = $urandom_range(0, 1) ? 7'h33 : 7'h3b;
            w[31:25] = 7'b0000001;
        end
        if (w == EBREAK_W) w = 32'h00000073;
        return w;
    endfunction

    // Monitor: out_valid is sampled at negedge; a transfer at the next posedge pops the model.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("d_out_valid", d_out_valid, exp_q.size() > 0);
            check("x_out_valid", x_out_valid, exp_q.size() > 0);
            check("n_out_valid", n_out_valid, exp_q.size() > 0);
            check("d_halted", d_halted, halted_m);
            check("x_halted", x_halted, halted_m);
            check("n_halted", n_halted, halted_m);
            if (exp_q.size() > 0 && out_ready) begin
                e = exp_q.pop_front();
                check("d_out_inst", d_inst, e.inst);
                check("d_out_pc", d_pc, e.pc);
                check("d_ctrl", act_d, e.b64);
                check("x_out_inst", x_inst, e.inst);
                check("x_out_pc", x_pc, e.pc[31:0]);
                check("x_ctrl", act_x, e.b32);
                check("n_out_pc", n_pc, e.pc);
                check("n_ctrl", act_n, e.bnm);
                if (e.inst == EBREAK_W) halted_m = 1'b1;
            end
        end
    end

    // One clock of stimulus: drive after posedge, check ready, then update the model after the monitor.
    task automatic cycle(input bit v, input logic [31:0] w, input logic [63:0] pc, input bit rdy, input bit fl);
        bit exp_ready, acc;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_inst   = w;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        #1;
        exp_ready = !halted_m && exp_q.size() < 2;
        check("d_in_ready", d_in_ready, exp_ready);
        check("x_in_ready", x_in_ready, exp_ready);
        check("n_in_ready", n_in_ready, exp_ready);
        acc = v && exp_ready;
        @(negedge clk);
        #2;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(mk(w, pc));
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_d_out_valid", d_out_valid, 0);
        check("rst_x_out_valid", x_out_valid, 0);
        check("rst_d_in_ready", d_in_ready, 0);
        check("rst_d_halted", d_halted, 0);
        check("rst_n_halted", n_halted, 0);
        exp_q.delete();
        halted_m = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0; flush = 0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_out_valid", d_out_valid, 0);
        check("reset_in_ready", d_in_ready, 0);
        check("reset_halted", d_halted, 0);
        check("reset_out_inst", d_inst, 0);
        check("reset_out_pc", d_pc, 0);
        check("reset_ctrl", act_d, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("release_in_ready", d_in_ready, 0);

        // addi with EX ready
        cycle(1, ADDI, 64'h8000_0000, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("addi_valid", d_out_valid, 1);
        check("addi_alu_src", d_alu_src, 1);
        check("addi_reg_w", d_reg_w, 1);
        check("addi_alu_op", d_alu_op, 4'b0011);
        check("addi_illegal", d_illegal, 0);

        // back-to-back with EX stalled two cycles
        cycle(1, LUI, 64'h100, 0, 0);
        cycle(1, LOAD, 64'h104, 0, 0);
        cycle(1, STORE, 64'h108, 0, 0);
        check("skid_full_in_ready", d_in_ready, 0);
        cycle(1, STORE, 64'h108, 1, 0);
        cycle(1, STORE, 64'h108, 1, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);

        // XLEN and M-extension variants
        cycle(1, ADDW, 64'h200, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("addw_x32_illegal", x_illegal, 1);
        check("addw_x32_ctrl", act_x, 17'h1);
        check("addw_x64_alu_op", d_alu_op, 4'b0110);
        check("addw_x64_illegal", d_illegal, 0);
        cycle(1, MUL, 64'h204, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("mul_nom_illegal", n_illegal, 1);
        check("mul_nom_ctrl", act_n, 17'h1);
        check("mul_m_alu_op", d_alu_op, 4'b1000);

        // flush with skid full, then flush discarding a same-cycle accept
        cycle(1, LUI, 64'h300, 0, 0);
        cycle(1, LOAD, 64'h304, 0, 0);
        cycle(1, ADDI, 64'h308, 0, 1);
        cycle(0, 0, 0, 1, 0);
        check("flush_out_valid", d_out_valid, 0);
        check("flush_in_ready", d_in_ready, 1);
        cycle(1, LUI, 64'h310, 0, 0);
        cycle(1, ADDI, 64'h314, 0, 1);
        repeat (2) cycle(0, 0, 0, 1, 0);

        // reset while stalled with both entries held
        cycle(1, LUI, 64'h400, 0, 0);
        cycle(1, LOAD, 64'h404, 0, 0);
        cycle(0, 0, 0, 0, 0);
        reset_mid();

        // ebreak halts; later addi never accepted; flush keeps halted
        cycle(1, EBREAK_W, 64'h500, 1, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (4) cycle(1, ADDI, 64'h504, 1, 0);
        check("ebreak_halted", d_halted, 1);
        check("ebreak_in_ready", d_in_ready, 0);
        check("ebreak_no_addi", d_out_valid, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        check("flush_keeps_halted", d_halted, 1);
        reset_mid();

        // ebreak transfer in the same cycle as flush still halts
        cycle(1, EBREAK_W, 64'h600, 0, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        check("ebreak_flush_halted", d_halted, 1);
        reset_mid();

        // randomized traffic
        repeat (600) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), {$urandom(), $urandom()},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        repeat (3) cycle(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050243_id_ctrl_stage.md
Name: ysyx_22050243_id_ctrl_stage

Overview:
- Registered instruction-decode/control stage. Sits between the IF stage and the EX stage of the pipelined core.
- Decodes a 32-bit instruction into the core's control bundle and holds it in an output register. A 1-entry skid buffer sits behind that register, and both sides use valid/ready handshakes.
- Generalised in three ways:
  - XLEN-parametrised: the *W instruction groups are legal only when XLEN=64.
  - Optional M extension.
  - Illegal-instruction flagging.
- ebreak produces a sticky `halted` output. It does not call a simulator hook.

Parameters:
- XLEN, 64, datapath width for PC passthrough; legal values are 32 and 64.
- HAS_M, 1, decode MUL/DIV/REM (OP/OP_32 with funct7=0000001) when 1; treat them as illegal when 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash all held instructions (redirect from EX)
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  control bundle valid
- out_ready  in  1  EX accepts
- out_inst  out  32  registered instruction
- out_pc  out  XLEN  registered PC
- out_alu_src  out  1  ALU operand B = immediate
- out_mem2reg  out  3  writeback select: 000 ALU, 001 mem, 010 imm, 011 PC+4, 100 PC+imm, 101 CSR
- out_reg_w  out  1  register write
- out_mem_r  out  1  load
- out_mem_w  out  1  store
- out_branch  out  1  conditional branch
- out_pc_src  out  2  next-PC select: 00 seq, 01 jal, 10 jalr
- out_alu_op  out  4  ALU class (see Behaviour)
- out_csr_r  out  1  CSR access
- out_illegal  out  1  instruction not legal under current parameters
- halted  out  1  sticky; set once ebreak has been accepted downstream

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0, including out_valid, halted, the skid buffer and the registered inst/pc; in_ready=0 while in reset.
  - in_ready=1 from the first clock after release.
- Handshake: a transfer happens when valid&&ready on the same clk edge.
- Latency: 1 cycle, in_valid accepted at edge N gives out_valid at N+1. Throughput is 1/cycle when out_ready=1.
- in_ready = !skid_valid && !halted (registered source, no combinational path from out_ready).
- Output register stalled (out_valid && !out_ready) when an input is accepted → the decoded entry goes to the skid buffer.
- Output register freed → the skid buffer drains into it before any new input.
- Full: skid_valid=1 → in_ready=0. Empty: out_valid=0 and skid_valid=0.
- Control bundle decoding is opcode-based:
  - LUI: mem2reg=010, reg_w=1.
  - AUIPC: mem2reg=100, reg_w=1.
  - JAL: mem2reg=011, reg_w=1, pc_src=01.
  - JALR: mem2reg=011, reg_w=1, pc_src=10.
  - BRANCH: branch=1, alu_op=0001.
  - LOAD: alu_src=1, mem2reg=001, reg_w=1, mem_r=1.
  - STORE: alu_src=1, mem_w=1.
  - OP_IMM: alu_src=1, reg_w=1, alu_op=0011.
  - OP: reg_w=1, alu_op=0010; with funct7=0000001 and HAS_M → alu_op=1000.
  - OP_IMM32: alu_src=1, reg_w=1, alu_op=0111.
  - OP_32: reg_w=1, alu_op=0110; with funct7=0000001 and HAS_M → alu_op=1001.
  - MISC_MEM (fence): all zero.
  - SYSTEM with funct3≠0: csr_r=1, mem2reg=101, reg_w=1.
  - SYSTEM with funct3=0: all zero.
- Illegal (bundle forced all-zero, illegal=1):
  - Unknown opcode.
  - in_inst==0.
  - OP_IMM32/OP_32 when XLEN=32.
  - funct7=0000001 on OP/OP_32 when HAS_M=0.
- Illegal instructions still flow through the handshake normally.
- ebreak (inst==32'h00100073): decodes to an all-zero bundle.
  - halted sets on the clk edge where it transfers out (out_valid&&out_ready).
  - From then on, in_ready=0 until reset. Entries already held still drain.
- flush: on the next edge, out_valid=0 and skid_valid=0.
  - An input accepted in the flush cycle is discarded.
  - flush does not clear halted.
  - An ebreak output-transfer in the same cycle as flush still sets halted (the output transfer completes).
- Reset mid-stall: all held entries are dropped immediately.

Decomposition:
- Shared package ysyx_22050243_pkg:
  - opcode constants (LUI…OP_32, MISC_MEM, SYSTEM).
  - mem2reg, pc_src and alu_op encodings.
  - a packed ctrl_t struct {csr_r, alu_src, mem2reg, reg_w, mem_r, mem_w, branch, pc_src, alu_op, illegal}.
  - EBREAK word constant.
- Sub-module ysyx_22050243_ctrl_dec: purely combinational inst → ctrl_t, parametrised by XLEN/HAS_M. The stage instantiates it once at the input and owns the output register, skid buffer and halt logic.

Test Plan:
- Reset, then feed addi x1,x0,5 (32'h00500093) with out_ready=1 → next cycle out_valid=1, alu_src=1, reg_w=1, alu_op=0011, illegal=0.
- Back-to-back LUI, LOAD (32'h0000b103), STORE with out_ready=0 for 2 cycles:
  - after 2 accepts, in_ready=0.
  - release out_ready → outputs appear in order LUI, LOAD, STORE with no loss or duplication.
- XLEN=32 instance, addw (32'h002081bb) → illegal=1 with an all-zero bundle. Default instance → alu_op=0110, illegal=0.
- HAS_M=0 instance, mul (32'h022080b3) → illegal=1. HAS_M=1 → alu_op=1000.
- ebreak followed by addi:
  - halted rises on the ebreak output transfer.
  - in_ready stays 0.
  - the addi is never emitted.
- flush asserted while the skid buffer is full → next cycle out_valid=0 and in_ready=1. An instruction offered during the flush cycle is not emitted.
